// File: rtl/exp_sweep_pkg.sv
// rtl/exp_sweep_pkg.sv - shared types and constants for the exponential growth sweep
package exp_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W_D    = 18;
    localparam int DEF_FRAC_D = 14;
    localparam int DEF_W_G    = 18;
    localparam int DEF_FRAC_G = 17;

    // Channel index width; a single channel still gets one bit.
    function automatic int CHAN_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fx_mul_round_sat.sv
// rtl/fx_mul_round_sat.sv - unsigned fixed-point multiply with round-half-up and saturation
module fx_mul_round_sat #(
    parameter int W_A    = 18,
    parameter int W_B    = 18,
    parameter int FRAC_B = 17
) (
    input  logic [W_A-1:0] a,
    input  logic [W_B-1:0] b,
    output logic [W_A-1:0] y,
    output logic           sat
);

    // One guard bit above the full product so the rounding add never wraps.
    localparam int W_P = W_A + W_B + 1;
    localparam int W_S = W_P - FRAC_B;
    localparam logic [W_P-1:0] HALF_LSB = W_P'(1) << (FRAC_B - 1);

    logic [W_P-1:0] prod_rnd;
    logic [W_S-1:0] scaled;

    // Full product, round half up at the growth-factor binary point, clamp to all-ones.
    always_comb begin
        prod_rnd = ({{(W_B + 1){1'b0}}, a} * {{(W_A + 1){1'b0}}, b}) + HALF_LSB;
        scaled   = W_S'(prod_rnd >> FRAC_B);
        sat      = |(scaled >> W_A);
        y        = sat ? {W_A{1'b1}} : scaled[W_A-1:0];
    end

endmodule

// File: rtl/exp_growth_sweep.sv
// rtl/exp_growth_sweep.sv - multi-channel geometric-recurrence price path generator
module exp_growth_sweep
    import exp_sweep_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int T_MIN  = 343,
    parameter int T_MAX  = 511,
    parameter int LOG_T  = 9,
    parameter int W_D    = DEF_W_D,
    parameter int FRAC_D = DEF_FRAC_D,
    parameter int W_G    = DEF_W_G,
    parameter int FRAC_G = DEF_FRAC_G
) (
    input  logic                      CLK,
    input  logic                      iRSTn,
    input  logic                      iStart,
    input  logic                      iAbort,
    input  logic [N_CH*W_D-1:0]       iSeed,
    input  logic [N_CH*W_G-1:0]       iGrowth,
    input  logic                      iReady,
    output logic                      oValid,
    output logic [W_D-1:0]            oData,
    output logic [LOG_T-1:0]          oAddr,
    output logic [CHAN_W(N_CH)-1:0]   oChan,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oSat
);

    localparam int              CW      = CHAN_W(N_CH);
    localparam logic [CW-1:0]   LAST_CH = CW'(N_CH - 1);
    localparam logic [LOG_T-1:0] T_FIRST = LOG_T'(T_MIN);
    localparam logic [LOG_T-1:0] T_LAST  = LOG_T'(T_MAX);

    // FRAC_D only names where the value's binary point sits; the recurrence is
    // scale-free in it. A value with no integer bits cannot grow, so such a
    // setting shows up as this named block in the elaborated hierarchy.
    if (FRAC_D >= W_D) begin : g_frac_d_leaves_no_integer_bits
    end

    state_t           state, state_nx;
    logic [W_D-1:0]   vreg [N_CH];
    logic [W_G-1:0]   greg [N_CH];
    logic [CW-1:0]    chan, chan_nx;
    logic [LOG_T-1:0] t, t_nx;
    logic [W_D-1:0]   prod, data_nx;
    logic             prod_sat;
    logic             start_ok, accept, last_beat;
    logic             valid_nx, busy_nx, done_nx;

    fx_mul_round_sat #(
        .W_A    (W_D),
        .W_B    (W_G),
        .FRAC_B (FRAC_G)
    ) u_mul (
        .a   (vreg[chan]),
        .b   (greg[chan]),
        .y   (prod),
        .sat (prod_sat)
    );

    // Next state, beat bookkeeping and next output flags.
    always_comb begin
        state_nx  = state;
        start_ok  = (state == IDLE) && iStart && !iAbort;
        accept    = (state == RUN) && iReady && !iAbort;
        last_beat = (t == T_LAST) && (chan == LAST_CH);
        chan_nx   = (chan == LAST_CH) ? '0 : chan + 1'b1;
        t_nx      = (chan == LAST_CH) ? t + 1'b1 : t;
        // With one channel the next beat is the value just being computed.
        data_nx   = (chan_nx == chan) ? prod : vreg[chan_nx];
        case (state)
            IDLE:    if (start_ok) state_nx = RUN;
            RUN: begin
                if (iAbort)                   state_nx = IDLE;
                else if (iReady && last_beat) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        valid_nx = (state_nx == RUN);
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state == RUN) && (state_nx == DONE);
    end

    // State register.
    always_ff @(posedge CLK or negedge iRSTn) begin
        if (!iRSTn) state <= IDLE;
        else        state <= state_nx;
    end

    // Channel storage, sweep position and registered beat outputs.
    always_ff @(posedge CLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int c = 0; c < N_CH; c++) begin
                vreg[c] <= '0;
                greg[c] <= '0;
            end
            chan   <= '0;
            t      <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oAddr  <= '0;
            oChan  <= '0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            oSat   <= 1'b0;
        end else begin
            oValid <= valid_nx;
            oBusy  <= busy_nx;
            oDone  <= done_nx;
            if (start_ok) begin
                for (int c = 0; c < N_CH; c++) begin
                    vreg[c] <= iSeed[c*W_D +: W_D];
                    greg[c] <= iGrowth[c*W_G +: W_G];
                end
                chan  <= '0;
                t     <= T_FIRST;
                oData <= iSeed[W_D-1:0];
                oAddr <= T_FIRST;
                oChan <= '0;
                oSat  <= 1'b0;
            end else if (accept) begin
                vreg[chan] <= prod;
                chan       <= chan_nx;
                t          <= t_nx;
                if (prod_sat) oSat <= 1'b1;
                // The final beat's outputs are left as they were; oValid drops.
                if (!last_beat) begin
                    oData <= data_nx;
                    oAddr <= t_nx;
                    oChan <= chan_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_exp_growth_sweep.sv
// tb/tb_exp_growth_sweep.sv - scoreboard bench for exp_growth_sweep
module tb_exp_growth_sweep;

    localparam int N_CH   = 4;
    localparam int T_MIN  = 343;
    localparam int T_MAX  = 351;
    localparam int LOG_T  = 9;
    localparam int W_D    = 18;
    localparam int FRAC_D = 14;
    localparam int W_G    = 18;
    localparam int FRAC_G = 17;
    localparam int CW     = 2;
    localparam int NBEAT  = (T_MAX - T_MIN + 1) * N_CH;

    logic                  CLK = 1'b0;
    logic                  iRSTn = 1'b0;
    logic                  iStart = 1'b0;
    logic                  iAbort = 1'b0;
    logic                  iReady = 1'b0;
    logic [N_CH*W_D-1:0]   iSeed = '0;
    logic [N_CH*W_G-1:0]   iGrowth = '0;
    logic                  oValid;
    logic [W_D-1:0]        oData;
    logic [LOG_T-1:0]      oAddr;
    logic [CW-1:0]         oChan;
    logic                  oBusy;
    logic                  oDone;
    logic                  oSat;

    exp_growth_sweep #(
        .N_CH(N_CH), .T_MIN(T_MIN), .T_MAX(T_MAX), .LOG_T(LOG_T),
        .W_D(W_D), .FRAC_D(FRAC_D), .W_G(W_G), .FRAC_G(FRAC_G)
    ) dut (
        .CLK(CLK), .iRSTn(iRSTn), .iStart(iStart), .iAbort(iAbort),
        .iSeed(iSeed), .iGrowth(iGrowth), .iReady(iReady),
        .oValid(oValid), .oData(oData), .oAddr(oAddr), .oChan(oChan),
        .oBusy(oBusy), .oDone(oDone), .oSat(oSat)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int data;
        int addr;
        int chan;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    exp_sat = 1'b0;
    bit    done_due = 1'b0;
    bit    rdy_rand = 1'b0;
    bit    rdy_fix = 1'b1;
    int    seed_v [N_CH];
    int    grow_v [N_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // V * G scaled back by 2^FRAC_G, rounded half up, clamped to the value range.
    function automatic longint r_mul(input longint v, input longint g, inout bit sat);
        longint r;
        r = (v * g + (64'd1 << (FRAC_G - 1))) / (64'd1 << FRAC_G);
        if (r >= (64'd1 << W_D)) begin
            sat = 1'b1;
            r   = (64'd1 << W_D) - 1;
        end
        return r;
    endfunction

    // Drive seeds/growths and queue the whole expected table for one run.
    task automatic load_and_plan();
        longint v [N_CH];
        bit s;
        s = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            iSeed[c*W_D +: W_D]   = W_D'(seed_v[c]);
            iGrowth[c*W_G +: W_G] = W_G'(grow_v[c]);
            v[c] = seed_v[c];
        end
        for (int t = T_MIN; t <= T_MAX; t++)
            for (int c = 0; c < N_CH; c++) begin
                exp_q.push_back('{int'(v[c]), t, c, (t == T_MAX) && (c == N_CH - 1)});
                v[c] = r_mul(v[c], grow_v[c], s);
            end
        exp_sat = s;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, oValid, 0);
        chk({tag, "_data"},  oData,  0);
        chk({tag, "_addr"},  oAddr,  0);
        chk({tag, "_chan"},  oChan,  0);
        chk({tag, "_busy"},  oBusy,  0);
        chk({tag, "_done"},  oDone,  0);
        chk({tag, "_sat"},   oSat,   0);
    endtask

    // Full run from IDLE; called one cycle after a posedge (#1 into the cycle).
    task automatic run(input bit random_ready, input bit poke_start);
        int cyc;
        rdy_rand = random_ready;
        rdy_fix  = 1'b1;
        load_and_plan();
        iStart = 1'b1;
        @(posedge CLK); #1;
        if (!poke_start) iStart = 1'b0;
        @(negedge CLK);
        chk("first_valid", oValid, 1);
        chk("first_busy", oBusy, 1);
        cyc = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (k > 1) @(negedge CLK);
            if (poke_start && k == 2) iSeed = '1;
            if (poke_start && k == 10) iStart = 1'b0;
            if (oDone) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) chk("done_timeout", 0, 1);
        else if (!random_ready) chk("done_cycle", cyc, NBEAT + 1);
        @(posedge CLK); #1;
        chk("busy_after_done", oBusy, 0);
        chk("queue_drained", exp_q.size(), 0);
        rdy_rand = 1'b0;
    endtask

    // Consumer ready: fixed or a fresh random value each cycle.
    initial forever begin
        @(posedge CLK); #1;
        iReady = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
    end

    // Monitor: pops an expected beat on each accept, checks stalls and oDone.
    initial begin
        beat_t e;
        bit stalled;
        logic [W_D-1:0] p_data;
        logic [LOG_T-1:0] p_addr;
        logic [CW-1:0] p_chan;
        stalled = 1'b0;
        forever begin
            @(negedge CLK);
            if (!iRSTn) begin
                stalled  = 1'b0;
                done_due = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("stall_valid", oValid, 1);
                chk("stall_data", oData, p_data);
                chk("stall_addr", oAddr, p_addr);
                chk("stall_chan", oChan, p_chan);
            end
            if (done_due) begin
                chk("done_pulse", oDone, 1);
                chk("done_valid_low", oValid, 0);
                chk("done_sat", oSat, exp_sat);
                done_due = 1'b0;
            end else begin
                chk("no_spurious_done", oDone, 0);
            end
            stalled = oValid && !iReady && !iAbort;
            p_data  = oData;
            p_addr  = oAddr;
            p_chan  = oChan;
            if (oValid && iReady && !iAbort) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", oData, e.data);
                    chk("beat_addr", oAddr, e.addr);
                    chk("beat_chan", oChan, e.chan);
                    if (e.last) done_due = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        @(posedge CLK); #1;
        iRSTn = 1'b1;
        @(posedge CLK); #1;

        // Start with abort asserted, and abort alone, are both ignored in IDLE.
        iStart = 1'b1;
        iAbort = 1'b1;
        @(posedge CLK); #1;
        iStart = 1'b0;
        @(negedge CLK);
        chk("start_with_abort_busy", oBusy, 0);
        chk("start_with_abort_valid", oValid, 0);
        @(posedge CLK); #1;
        iAbort = 1'b0;

        // Saturating 1.5x, rounding 3->5->8, G=0, G=1.0; ready tied high.
        seed_v = '{16384, 3, 100000, 12345};
        grow_v = '{196608, 196608, 0, 131072};
        run(1'b0, 1'b0);

        // Back-to-back start with G=1.0, iStart held and iSeed corrupted while busy.
        seed_v = '{100, 200, 300, 400};
        grow_v = '{131072, 131072, 131072, 131072};
        run(1'b0, 1'b1);
        iSeed = '0;
        @(posedge CLK); #1;

        // Random values under random backpressure.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                seed_v[c] = $urandom_range(0, (1 << W_D) - 1);
                grow_v[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(110000, 160000)
                                                        : $urandom_range(0, (1 << W_G) - 1);
            end
            run(1'b1, 1'b0);
        end

        // Abort on beat 5: no oDone, busy and valid drop next cycle.
        seed_v = '{1000, 2000, 3000, 4000};
        grow_v = '{140000, 150000, 131072, 65536};
        load_and_plan();
        iStart = 1'b1;
        @(posedge CLK); #1;
        iStart = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        iAbort = 1'b1;
        @(posedge CLK); #1;
        iAbort = 1'b0;
        @(negedge CLK);
        chk("abort_valid", oValid, 0);
        chk("abort_busy", oBusy, 0);
        chk("abort_done", oDone, 0);
        chk("abort_left_beats", exp_q.size(), NBEAT - 4);
        repeat (4) @(posedge CLK);
        #1;
        exp_q.delete();

        // Reset in the middle of a run clears every output at once.
        load_and_plan();
        iStart = 1'b1;
        @(posedge CLK); #1;
        iStart = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        iRSTn = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        exp_q.delete();
        @(posedge CLK); #1;
        @(posedge CLK); #2;
        iRSTn = 1'b1;
        @(posedge CLK); #1;

        // Recovery after reset.
        seed_v = '{5, 7, 9, 11};
        grow_v = '{200000, 262143, 131071, 131073};
        run(1'b1, 1'b0);

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exp_growth_sweep.md
# exp_growth_sweep

Multi-channel, parametrised generator of the price-path table S0·exp(t·mu) for every t in [T_MIN, T_MAX]. It replaces the single-channel direct-exponential sweep with a geometric recurrence, V(t+1) = V(t)·G, where G = exp(mu) is supplied per channel. Channels are time-multiplexed onto one rounding/saturating multiplier. The block sits between the parameter loader, which supplies the seeds and growth factors, and the risk-table RAM writer, which consumes oData/oAddr/oChan.

## Interface
- N_CH, 4: number of channels (assets); ≥1
- T_MIN, 343: first time index
- T_MAX, 511: last time index; T_MAX ≥ T_MIN
- LOG_T, 9: width of the time index
- W_D, 18: value width, unsigned
- FRAC_D, 14: fraction bits of the value
- W_G, 18: growth-factor width, unsigned
- FRAC_G, 17: fraction bits of the growth factor
- CLK  in  1  clock, rising edge
- iRSTn  in  1  asynchronous active-low reset
- iStart  in  1  run request; sampled in IDLE only
- iAbort  in  1  synchronous abort; returns to IDLE, no oDone
- iSeed  in  N_CH*W_D  per-channel V(T_MIN), channel c at bits [c*W_D +: W_D]
- iGrowth  in  N_CH*W_G  per-channel G, same packing
- iReady  in  1  consumer accepts the current beat
- oValid  out  1  beat valid
- oData  out  W_D  V(t) for oChan
- oAddr  out  LOG_T  t
- oChan  out  max(1,clog2(N_CH))  channel index
- oBusy  out  1  high from start acceptance until oDone
- oDone  out  1  one-cycle pulse after the last beat is accepted
- oSat  out  1  sticky: at least one saturation this run

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, iStart=1: latch iSeed into the per-channel value registers and iGrowth into growth registers; clear oSat; t←T_MIN, chan←0; go to RUN. iSeed/iGrowth are ignored at all other times.
- RUN: oValid=1, oData=Vreg[chan], oAddr=t, oChan=chan.
- On iValid∧iReady (accept):
  - Vreg[chan] ← R(Vreg[chan]·Greg[chan]).
  - chan increments. On wrap past N_CH-1, chan←0 and t increments.
  - Accepting the beat (t=T_MAX, chan=N_CH-1) → DONE.
- Stall: iReady=0 holds all outputs and state unchanged.
- DONE: single cycle. oDone=1, oValid=0; then IDLE. oBusy falls with DONE exit.
- R(p): full product p (W_D+W_G bits), then +2^(FRAC_G-1), then >>FRAC_G (round half up). If the result ≥ 2^W_D, output all-ones and set oSat. A saturated channel stays at all-ones while G ≥ 1.0.
- G=0 gives zeros after the seed beat; G=1.0 (2^FRAC_G) holds the value exactly.
- iAbort in RUN or DONE: go to IDLE next cycle, oValid=0, no oDone; registers keep their contents. iAbort has priority over accept. iAbort in IDLE has no effect.
- iStart during RUN/DONE is ignored. iStart in IDLE with iAbort=1 is ignored.
- Reset mid-run: immediate IDLE, all outputs 0.

## Timing
- All outputs are registered. Reset values: oValid=0, oData=0, oAddr=0, oChan=0, oBusy=0, oDone=0, oSat=0; state IDLE.
- Start is accepted in cycle 0. The first beat (t=T_MIN, ch 0, data = seed 0) is valid in cycle 1.
- With iReady tied high: one beat per cycle. Total beats = (T_MAX−T_MIN+1)·N_CH. The last beat is in cycle B. oDone is in cycle B+1. The earliest new start is accepted in cycle B+2.
- No loop-carried hazard: the multiply is single-cycle into the value register.

## Structure
- Package exp_sweep_pkg:
  - state enum {IDLE, RUN, DONE}
  - default width constants (W_D, FRAC_D, W_G, FRAC_G)
  - CHAN_W function: max(1, clog2(N))
- Sub-module fx_mul_round_sat (params W_A, W_B, FRAC_B; inputs a, b; outputs y, sat): purely combinational multiply/round/saturate. It is reused by later pricing blocks.
- Per-channel value and growth storage are register arrays, not RAM.

## Test plan
- N_CH=1, T_MIN=0, T_MAX=3, seed=16384 (1.0), G=196608 (1.5), iReady=1 → data 16384, 24576, 36864, 55296 at addr 0..3; oDone one cycle after the addr 3 beat; oSat=0.
- Same seed and G, T_MAX=8 → …124416, 186624, then 262143 at addr 7 and addr 8; oSat=1.
- Rounding: seed=3, G=196608 → 3, 5, 8 (4.5→5, 7.5→8).
- N_CH=4, seeds 100/200/300/400, G=131072 (1.0), T_MIN=343, T_MAX=344 → 8 beats in order ch0..3 at t=343, then ch0..3 at t=344; data equals the seeds; oChan and oAddr match.
- Backpressure: iReady pattern 1,0,0,1,0,1… → no beat lost or duplicated; outputs stable while stalled; beat count and oDone timing follow the accepts.
- iAbort at beat 5 → oValid low next cycle, no oDone, oBusy low. Then iRSTn low mid-run of a new start → all outputs 0 immediately; iStart while busy ignored.
